match_result_bus: RTL and testbench
===================================

Name: match_result_bus

Overview:
- One node of the daisy-chained return bus that gathers match-sequence results from the job PEs and delivers them to the sequence sink in job order.
- Each node merges its local PE's sequence stream with the stream arriving from the upstream node and drives the downstream node.
- The tail node (IDX=0) feeds the sink. Job order is enforced by a round-robin turn counter, advanced by a commit pulse that the tail broadcasts to every node.
- It is the collecting counterpart of the hash-result distribution bus, which routes results out to the PEs by head-address PE index.

Parameters:
- IDX, 0, this node's PE index, `NUM_JOB_PE_LOG2` bits.
- PIPED, 0, 0 = combinational output path; 1 = registered output stage (2-entry skid buffer, full throughput).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_local_valid  in  1  local PE sequence beat valid
- i_local_head_addr  in  `ADDR_WIDTH`  job-relative head address of the sequence
- i_local_lit_len  in  `SEQ_LL_BITS`  literal length
- i_local_match_len  in  `SEQ_ML_BITS`  match length (0 = literal-only)
- i_local_offset  in  `ADDR_WIDTH`  match offset
- i_local_eoj  in  1  last beat of the job
- i_local_ready  out  1  local beat accepted
- i_up_valid, i_up_head_addr, i_up_lit_len, i_up_match_len, i_up_offset, i_up_eoj  in  same widths  upstream-node stream
- i_up_ready  out  1  upstream beat accepted
- o_valid, o_head_addr, o_lit_len, o_match_len, o_offset, o_eoj  out  same widths  downstream stream
- o_ready  in  1  downstream ready
- i_commit_eoj  in  1  one-cycle pulse from the tail: an eoj beat has been handshaked into the sink
- o_turn  out  `NUM_JOB_PE_LOG2`  current expected PE index (debug)

Behaviour:
- Turn counter `turn`: reset 0. On i_commit_eoj it increments modulo NUM_JOB_PE (power of 2, natural wrap). All nodes receive the same pulse, so all counters stay equal.
- Local FSM, reset to WAIT.
  - WAIT: local path blocked (i_local_ready=0). If turn==IDX, go to OWN next cycle.
  - OWN: the mux selects local; i_local_ready follows the internal ready. A local handshake with eoj=1 goes to DRAIN.
  - DRAIN: local path blocked until the commit pulse for this job arrives (i_commit_eoj=1 seen in DRAIN), then go to WAIT. This prevents the next job's beats leaving before the eoj reaches the sink through downstream pipeline stages.
- Mux select: state==OWN → local; otherwise upstream.
  - i_up_ready = internal ready when state!=OWN, else 0.
  - Upstream beats pass unchanged, including eoj.
- Turn and commit pulse in the same cycle: the increment happens first; the FSM evaluates turn==IDX on the next cycle.
- A commit pulse in WAIT or OWN only advances turn. It does not change state.
- Payload and valid must be stable while valid && !ready (AXI-style). The node never drops or reorders beats within a source.
- PIPED=0: o_* = selected source combinationally; internal ready = o_ready; latency 0.
- PIPED=1: 2-entry skid buffer; latency 1 cycle; throughput 1 beat/cycle.
  - Internal ready = buffer not full.
  - Reset: buffer empty.
- Reset values: o_valid=0, i_local_ready=0, i_up_ready=0 (in PIPED=0 while the selected source is not ready), o_turn=0. Data outputs are don't-care when o_valid=0; the PIPED=1 registers clear to 0.
- Reset mid-operation: the buffer is flushed, the FSM returns to WAIT, turn=0. Upstream producers reset in the same cycle.
- NUM_JOB_PE=1: turn is constant 0. The FSM still cycles WAIT→OWN→DRAIN→WAIT per job.

Optional Feature:
- Macro: MATCH_RESULT_BUS_ORDER_CHECK_EN.
- Defined: adds output o_order_err (1 bit, sticky, cleared only by rst). It sets when any upstream beat is handshaked with head-addr PE-index field != turn, or when i_commit_eoj arrives while the tail node (IDX=0) is not in DRAIN and turn==IDX.
- Undefined: the port and the check logic are absent. Functional behaviour is identical.

Decomposition:
- parameters.vh / shared package: `SEQ_LL_BITS`, `SEQ_ML_BITS`, `NUM_JOB_PE_LOG2`, `JOB_LEN_LOG2`; packed seq_beat_t {head_addr, lit_len, match_len, offset, eoj}; FSM state enum.
- One sub-module: the PIPED=1 output stage as seq_skid_buffer (generic width, 2 entries). It is reusable by the other chained buses.

Test Plan:
- NUM_JOB_PE=4, IDX=2, PIPED=0: local presents 3 beats (eoj on the last) while turn=0 → i_local_ready=0. Two commit pulses → turn=2; the 3 beats pass in 3 cycles, then the FSM sits in DRAIN.
- IDX=2 in DRAIN, local offers the next job's beat → blocked. Commit pulse → turn=3, FSM to WAIT, still blocked. Wrap pulse (turn 3→0) and 2 more → accepted.
- PIPED=1, o_ready toggles 1,0,1,0 while upstream streams 8 beats → all 8 arrive in order, no drops; the first appears 1 cycle after the first accept.
- PIPED=1 full-rate: o_ready=1, upstream valid every cycle → one beat out per cycle after 1-cycle latency.
- Assert rst mid-stream with 1 beat buffered → next cycle o_valid=0, turn=0, FSM WAIT.
- With MATCH_RESULT_BUS_ORDER_CHECK_EN: inject an upstream beat with PE index 3 while turn=1 → o_order_err=1 and stays set until rst.

Source files
------------

// File: rtl/match_result_bus_pkg.sv
// Shared widths, sequence beat layout and node FSM states for the match-result return bus.
package match_result_bus_pkg;

    localparam int NUM_JOB_PE_LOG2 = 2;
    localparam int NUM_JOB_PE      = 1 << NUM_JOB_PE_LOG2;
    localparam int JOB_LEN_LOG2    = 8;
    localparam int ADDR_WIDTH      = JOB_LEN_LOG2 + NUM_JOB_PE_LOG2;
    localparam int SEQ_LL_BITS     = 8;
    localparam int SEQ_ML_BITS     = 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  head_addr;
        logic [SEQ_LL_BITS-1:0] lit_len;
        logic [SEQ_ML_BITS-1:0] match_len;
        logic [ADDR_WIDTH-1:0]  offset;
        logic                   eoj;
    } seq_beat_t;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2
    } bus_state_t;

    // The PE that produced a sequence is encoded in the top bits of its head address.
    function automatic logic [NUM_JOB_PE_LOG2-1:0] pe_of(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1 -: NUM_JOB_PE_LOG2];
    endfunction

endpackage

// File: rtl/seq_skid_buffer.sv
// Generic 2-entry registered skid buffer; ready depends only on fill level, so
// a full-rate stream passes with one cycle of latency.
module seq_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = rd_ptr_q ? entry1_q : entry0_q;

    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        if (push && !wr_ptr_q) entry0_d = in_data;
        if (push && wr_ptr_q)  entry1_d = in_data;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/match_result_bus.sv
// One node of the daisy-chained match-result return bus: merges the local PE stream
// into the upstream stream in job order. Optional MATCH_RESULT_BUS_ORDER_CHECK_EN adds o_order_err.
module match_result_bus
    import match_result_bus_pkg::*;
#(
    parameter int unsigned IDX   = 0,
    parameter int          PIPED = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_local_valid,
    input  logic [ADDR_WIDTH-1:0]      i_local_head_addr,
    input  logic [SEQ_LL_BITS-1:0]     i_local_lit_len,
    input  logic [SEQ_ML_BITS-1:0]     i_local_match_len,
    input  logic [ADDR_WIDTH-1:0]      i_local_offset,
    input  logic                       i_local_eoj,
    output logic                       i_local_ready,
    input  logic                       i_up_valid,
    input  logic [ADDR_WIDTH-1:0]      i_up_head_addr,
    input  logic [SEQ_LL_BITS-1:0]     i_up_lit_len,
    input  logic [SEQ_ML_BITS-1:0]     i_up_match_len,
    input  logic [ADDR_WIDTH-1:0]      i_up_offset,
    input  logic                       i_up_eoj,
    output logic                       i_up_ready,
    output logic                       o_valid,
    output logic [ADDR_WIDTH-1:0]      o_head_addr,
    output logic [SEQ_LL_BITS-1:0]     o_lit_len,
    output logic [SEQ_ML_BITS-1:0]     o_match_len,
    output logic [ADDR_WIDTH-1:0]      o_offset,
    output logic                       o_eoj,
    input  logic                       o_ready,
    input  logic                       i_commit_eoj,
`ifdef MATCH_RESULT_BUS_ORDER_CHECK_EN
    output logic                       o_order_err,
`endif
    output logic [NUM_JOB_PE_LOG2-1:0] o_turn
);

    localparam logic [NUM_JOB_PE_LOG2-1:0] IDX_L = NUM_JOB_PE_LOG2'(IDX);

    bus_state_t                 state_q, state_d;
    logic [NUM_JOB_PE_LOG2-1:0] turn_q, turn_d;
    seq_beat_t                  sel_beat, out_beat;
    logic                       sel_valid;
    logic                       local_sel;
    logic                       int_ready;

    assign local_sel = (state_q == ST_OWN);
    assign o_turn    = turn_q;

    // DRAIN holds off the next job until the tail confirms our eoj reached the sink.
    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        if (i_commit_eoj) turn_d = turn_q + NUM_JOB_PE_LOG2'(1);
        case (state_q)
            ST_WAIT:  if (turn_q == IDX_L) state_d = ST_OWN;
            ST_OWN:   if (i_local_valid && int_ready && i_local_eoj) state_d = ST_DRAIN;
            ST_DRAIN: if (i_commit_eoj) state_d = ST_WAIT;
            default:  state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
        end
    end

    always_comb begin
        sel_valid     = i_up_valid;
        sel_beat      = '{head_addr: i_up_head_addr, lit_len: i_up_lit_len,
                          match_len: i_up_match_len, offset: i_up_offset, eoj: i_up_eoj};
        i_local_ready = 1'b0;
        i_up_ready    = int_ready;
        if (local_sel) begin
            sel_valid     = i_local_valid;
            sel_beat      = '{head_addr: i_local_head_addr, lit_len: i_local_lit_len,
                              match_len: i_local_match_len, offset: i_local_offset,
                              eoj: i_local_eoj};
            i_local_ready = int_ready;
            i_up_ready    = 1'b0;
        end
    end

    generate
        if (PIPED != 0) begin : g_piped
            logic [$bits(seq_beat_t)-1:0] skid_out;
            seq_skid_buffer #(
                .WIDTH($bits(seq_beat_t))
            ) u_skid (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (sel_valid),
                .in_data   (sel_beat),
                .in_ready  (int_ready),
                .out_valid (o_valid),
                .out_data  (skid_out),
                .out_ready (o_ready)
            );
            assign out_beat = seq_beat_t'(skid_out);
        end else begin : g_comb
            assign o_valid   = sel_valid;
            assign out_beat  = sel_beat;
            assign int_ready = o_ready;
        end
    endgenerate

    assign o_head_addr = out_beat.head_addr;
    assign o_lit_len   = out_beat.lit_len;
    assign o_match_len = out_beat.match_len;
    assign o_offset    = out_beat.offset;
    assign o_eoj       = out_beat.eoj;

`ifdef MATCH_RESULT_BUS_ORDER_CHECK_EN
    logic order_err_q, order_err_d;

    // Sticky flag: a foreign-job beat passing through, or a commit the tail never owned.
    always_comb begin
        order_err_d = order_err_q;
        if (i_up_valid && i_up_ready && (pe_of(i_up_head_addr) != turn_q))
            order_err_d = 1'b1;
        if ((IDX_L == '0) && i_commit_eoj && (state_q != ST_DRAIN) && (turn_q == IDX_L))
            order_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) order_err_q <= 1'b0;
        else     order_err_q <= order_err_d;
    end

    assign o_order_err = order_err_q;
`endif

endmodule

// File: tb/tb_match_result_bus.sv
// Self-checking bench: node A (IDX=2, combinational) for job ordering, node B (IDX=3,
// registered) for the skid path against a queue scoreboard.
module tb_match_result_bus;
    import match_result_bus_pkg::*;

    localparam int PW = 2 * ADDR_WIDTH + SEQ_LL_BITS + SEQ_ML_BITS + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic                       a_local_valid, a_local_eoj, a_local_ready;
    logic [ADDR_WIDTH-1:0]      a_local_head, a_local_off;
    logic [SEQ_LL_BITS-1:0]     a_local_ll;
    logic [SEQ_ML_BITS-1:0]     a_local_ml;
    logic                       a_up_valid, a_up_eoj, a_up_ready;
    logic [ADDR_WIDTH-1:0]      a_up_head, a_up_off;
    logic [SEQ_LL_BITS-1:0]     a_up_ll;
    logic [SEQ_ML_BITS-1:0]     a_up_ml;
    logic                       a_o_valid, a_o_eoj, a_o_ready, a_commit;
    logic [ADDR_WIDTH-1:0]      a_o_head, a_o_off;
    logic [SEQ_LL_BITS-1:0]     a_o_ll;
    logic [SEQ_ML_BITS-1:0]     a_o_ml;
    logic [NUM_JOB_PE_LOG2-1:0] a_turn;

    logic                       b_local_valid, b_local_eoj, b_local_ready;
    logic [ADDR_WIDTH-1:0]      b_local_head, b_local_off;
    logic [SEQ_LL_BITS-1:0]     b_local_ll;
    logic [SEQ_ML_BITS-1:0]     b_local_ml;
    logic                       b_up_valid, b_up_eoj, b_up_ready;
    logic [ADDR_WIDTH-1:0]      b_up_head, b_up_off;
    logic [SEQ_LL_BITS-1:0]     b_up_ll;
    logic [SEQ_ML_BITS-1:0]     b_up_ml;
    logic                       b_o_valid, b_o_eoj, b_o_ready, b_commit;
    logic [ADDR_WIDTH-1:0]      b_o_head, b_o_off;
    logic [SEQ_LL_BITS-1:0]     b_o_ll;
    logic [SEQ_ML_BITS-1:0]     b_o_ml;
    logic [NUM_JOB_PE_LOG2-1:0] b_turn;

`ifdef MATCH_RESULT_BUS_ORDER_CHECK_EN
    logic a_order_err, b_order_err;
`endif

    match_result_bus #(.IDX(2), .PIPED(0)) dut_a (
        .clk(clk), .rst(rst),
        .i_local_valid(a_local_valid), .i_local_head_addr(a_local_head),
        .i_local_lit_len(a_local_ll), .i_local_match_len(a_local_ml),
        .i_local_offset(a_local_off), .i_local_eoj(a_local_eoj),
        .i_local_ready(a_local_ready),
        .i_up_valid(a_up_valid), .i_up_head_addr(a_up_head),
        .i_up_lit_len(a_up_ll), .i_up_match_len(a_up_ml),
        .i_up_offset(a_up_off), .i_up_eoj(a_up_eoj), .i_up_ready(a_up_ready),
        .o_valid(a_o_valid), .o_head_addr(a_o_head), .o_lit_len(a_o_ll),
        .o_match_len(a_o_ml), .o_offset(a_o_off), .o_eoj(a_o_eoj),
        .o_ready(a_o_ready), .i_commit_eoj(a_commit),
`ifdef MATCH_RESULT_BUS_ORDER_CHECK_EN
        .o_order_err(a_order_err),
`endif
        .o_turn(a_turn)
    );

    match_result_bus #(.IDX(3), .PIPED(1)) dut_b (
        .clk(clk), .rst(rst),
        .i_local_valid(b_local_valid), .i_local_head_addr(b_local_head),
        .i_local_lit_len(b_local_ll), .i_local_match_len(b_local_ml),
        .i_local_offset(b_local_off), .i_local_eoj(b_local_eoj),
        .i_local_ready(b_local_ready),
        .i_up_valid(b_up_valid), .i_up_head_addr(b_up_head),
        .i_up_lit_len(b_up_ll), .i_up_match_len(b_up_ml),
        .i_up_offset(b_up_off), .i_up_eoj(b_up_eoj), .i_up_ready(b_up_ready),
        .o_valid(b_o_valid), .o_head_addr(b_o_head), .o_lit_len(b_o_ll),
        .o_match_len(b_o_ml), .o_offset(b_o_off), .o_eoj(b_o_eoj),
        .o_ready(b_o_ready), .i_commit_eoj(b_commit),
`ifdef MATCH_RESULT_BUS_ORDER_CHECK_EN
        .o_order_err(b_order_err),
`endif
        .o_turn(b_turn)
    );

    int               m_turn = 0;
    logic [PW-1:0]    sb[$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseCommitA();
        a_commit = 1'b1;
        step();
        a_commit = 1'b0;
        m_turn = (m_turn + 1) % NUM_JOB_PE;
    endtask

    task automatic applyStimulus();
        a_up_valid    = 1'($urandom_range(0, 1));
        a_up_head     = ADDR_WIDTH'($urandom);
        a_up_ll       = SEQ_LL_BITS'($urandom);
        a_up_ml       = SEQ_ML_BITS'($urandom);
        a_up_off      = ADDR_WIDTH'($urandom);
        a_up_eoj      = 1'($urandom_range(0, 1));
        a_o_ready     = 1'($urandom_range(0, 1));
        a_local_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic setLocalA(input int pe, input int k, input logic eoj);
        a_local_valid = 1'b1;
        a_local_head  = {NUM_JOB_PE_LOG2'(pe), JOB_LEN_LOG2'(k * 16)};
        a_local_ll    = SEQ_LL_BITS'(k + 1);
        a_local_ml    = SEQ_ML_BITS'(k + 3);
        a_local_off   = ADDR_WIDTH'(k + 7);
        a_local_eoj   = eoj;
    endtask

    task automatic newBeatB();
        b_up_valid = 1'b1;
        b_up_head  = ADDR_WIDTH'($urandom);
        b_up_ll    = SEQ_LL_BITS'($urandom);
        b_up_ml    = SEQ_ML_BITS'($urandom);
        b_up_off   = ADDR_WIDTH'($urandom);
        b_up_eoj   = 1'($urandom_range(0, 1));
    endtask

    // mode 0: full rate, 1: o_ready toggles 1,0,..., 2: random valid and ready
    task automatic runB(input int nbeats, input int mode, input int budget);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        logic [PW-1:0] exp_beat;
        b_up_valid = 1'b0;
        while (got < nbeats && cyc < budget) begin
            if (!b_up_valid && sent < nbeats) begin
                if (mode != 2 || $urandom_range(0, 9) < 7) newBeatB();
            end
            case (mode)
                0:       b_o_ready = 1'b1;
                1:       b_o_ready = (cyc % 2 == 0);
                default: b_o_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (mode == 0) begin
                checkOutput("b_full_valid", 64'(b_o_valid), 64'(cyc >= 1));
                if (cyc < nbeats) checkOutput("b_full_up_ready", 64'(b_up_ready), 64'd1);
            end
            if (b_o_valid && b_o_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("b_extra_beat", 64'd1, 64'd0);
                end else begin
                    exp_beat = sb.pop_front();
                    checkOutput("b_beat", 64'({b_o_head, b_o_ll, b_o_ml, b_o_off, b_o_eoj}),
                                64'(exp_beat));
                    got++;
                end
            end
            if (b_up_valid && b_up_ready) begin
                sb.push_back({b_up_head, b_up_ll, b_up_ml, b_up_off, b_up_eoj});
                sent++;
                step();
                b_up_valid = 1'b0;
            end else begin
                step();
            end
            cyc++;
        end
        b_up_valid = 1'b0;
        checkOutput("b_beats_delivered", 64'(got), 64'(nbeats));
    endtask

    initial begin
        a_local_valid = 0; a_local_head = '0; a_local_ll = '0; a_local_ml = '0;
        a_local_off = '0; a_local_eoj = 0;
        a_up_valid = 0; a_up_head = '0; a_up_ll = '0; a_up_ml = '0; a_up_off = '0; a_up_eoj = 0;
        a_o_ready = 0; a_commit = 0;
        b_local_valid = 0; b_local_head = '0; b_local_ll = '0; b_local_ml = '0;
        b_local_off = '0; b_local_eoj = 0;
        b_up_valid = 0; b_up_head = '0; b_up_ll = '0; b_up_ml = '0; b_up_off = '0; b_up_eoj = 0;
        b_o_ready = 0; b_commit = 0;

        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("a_reset_o_valid", 64'(a_o_valid), 64'd0);
        checkOutput("a_reset_local_ready", 64'(a_local_ready), 64'd0);
        checkOutput("a_reset_turn", 64'(a_turn), 64'd0);
        checkOutput("b_reset_o_valid", 64'(b_o_valid), 64'd0);
        checkOutput("b_reset_turn", 64'(b_turn), 64'd0);
        step();

        // Node A not on turn: upstream passes straight through.
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            @(negedge clk);
            checkOutput("a_pass_valid", 64'(a_o_valid), 64'(a_up_valid));
            checkOutput("a_pass_payload", 64'({a_o_head, a_o_ll, a_o_ml, a_o_off, a_o_eoj}),
                        64'({a_up_head, a_up_ll, a_up_ml, a_up_off, a_up_eoj}));
            checkOutput("a_pass_up_ready", 64'(a_up_ready), 64'(a_o_ready));
            checkOutput("a_pass_local_blocked", 64'(a_local_ready), 64'd0);
            step();
        end

        a_up_valid = 1'b0;
        a_o_ready  = 1'b1;
        setLocalA(2, 0, 1'b0);
        @(negedge clk);
        checkOutput("a_local_blocked_turn0", 64'(a_local_ready), 64'd0);
        step();
        pulseCommitA();
        pulseCommitA();
        @(negedge clk);
        checkOutput("a_turn_after_2", 64'(a_turn), 64'(m_turn));
        checkOutput("a_wait_one_cycle", 64'(a_local_ready), 64'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            setLocalA(2, k, k == 2);
            @(negedge clk);
            checkOutput("a_own_ready", 64'(a_local_ready), 64'd1);
            checkOutput("a_own_valid", 64'(a_o_valid), 64'd1);
            checkOutput("a_own_payload", 64'({a_o_head, a_o_ll, a_o_ml, a_o_off, a_o_eoj}),
                        64'({a_local_head, a_local_ll, a_local_ml, a_local_off, a_local_eoj}));
            checkOutput("a_own_up_blocked", 64'(a_up_ready), 64'd0);
            step();
        end

        // Draining: next job blocked, upstream flows again.
        setLocalA(2, 5, 1'b0);
        a_up_valid = 1'b1;
        a_up_head  = {NUM_JOB_PE_LOG2'(2), JOB_LEN_LOG2'(200)};
        @(negedge clk);
        checkOutput("a_drain_blocked", 64'(a_local_ready), 64'd0);
        checkOutput("a_drain_up_ready", 64'(a_up_ready), 64'd1);
        checkOutput("a_drain_up_head", 64'(a_o_head), 64'(a_up_head));
        step();
        a_up_valid = 1'b0;
        pulseCommitA();
        @(negedge clk);
        checkOutput("a_turn3", 64'(a_turn), 64'(m_turn));
        checkOutput("a_wait_blocked", 64'(a_local_ready), 64'd0);
        step();
        pulseCommitA();
        pulseCommitA();
        pulseCommitA();
        @(negedge clk);
        checkOutput("a_turn_wrapped", 64'(a_turn), 64'(m_turn));
        checkOutput("a_wait_again", 64'(a_local_ready), 64'd0);
        step();
        @(negedge clk);
        checkOutput("a_next_job_ready", 64'(a_local_ready), 64'd1);
        checkOutput("a_next_job_head", 64'(a_o_head), 64'(a_local_head));

        // Node B, registered path.
        step();
        a_local_valid = 1'b0;
        runB(8, 0, 40);
        runB(8, 1, 60);
        runB(40, 2, 600);
        checkOutput("b_scoreboard_empty", 64'(sb.size()), 64'd0);

        newBeatB();
        b_o_ready     = 1'b0;
        b_local_valid = 1'b1;
        step();
        b_up_valid = 1'b0;
        @(negedge clk);
        checkOutput("b_buffered_valid", 64'(b_o_valid), 64'd1);
        pulseCommitA();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_turn = 0;
        @(negedge clk);
        checkOutput("b_rst_o_valid", 64'(b_o_valid), 64'd0);
        checkOutput("b_rst_turn", 64'(b_turn), 64'd0);
        checkOutput("b_rst_local_ready", 64'(b_local_ready), 64'd0);
        checkOutput("a_rst_turn", 64'(a_turn), 64'(m_turn));
        b_local_valid = 1'b0;
        step();

`ifdef MATCH_RESULT_BUS_ORDER_CHECK_EN
        pulseCommitA();
        a_up_valid = 1'b1;
        a_up_head  = {NUM_JOB_PE_LOG2'(3), JOB_LEN_LOG2'(9)};
        a_o_ready  = 1'b1;
        @(negedge clk);
        checkOutput("a_order_err_clear", 64'(a_order_err), 64'd0);
        step();
        a_up_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("a_order_err_sticky", 64'(a_order_err), 64'd1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("a_order_err_rst", 64'(a_order_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
